issue_ctrl: RTL and testbench

ISSUE_CTRL -- requirements
Module: issue_ctrl

---
 rtl/issue_ctrl_pkg.sv | 19 +
 rtl/instr_fifo.sv | 89 ++++++++
 rtl/issue_ctrl.sv | 142 ++++++++++++++
 tb/tb_issue_ctrl.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_ctrl_pkg.sv
// Shared definitions for the issue controller slice.
//   PcLength / InstrLength : MSB index of PC and instruction words.
//   QueueDepthDefault / QueueAddrLengthDefault : default queue geometry.
//   state_e : issue FSM encoding (IDLE, ISSUE, STALL, FLUSH).
package issue_ctrl_pkg;

  localparam int PcLength               = 31;
  localparam int InstrLength            = 31;
  localparam int QueueDepthDefault      = 16;
  localparam int QueueAddrLengthDefault = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // queue empty
    ISSUE = 2'd1,  // head issued last cycle or just arrived
    STALL = 2'd2,  // head present but blocked by a downstream full flag
    FLUSH = 2'd3   // one-cycle redirect after a rob jump request
  } state_e;

endpackage

// File: rtl/instr_fifo.sv
// Circular instruction queue holding {pc, instr} pairs.
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   clear_i         : drop all entries at the next edge (wins over push/pop)
//   push_i, pop_i   : enqueue at tail / dequeue head at the next edge
//   push_pc_i, push_instr_i : entry written on push
//   full_o, empty_o : registered occupancy flags
//   next_empty_o    : occupancy after this edge is zero
//   head_pc_o, head_instr_o : head entry, zero while empty
// Storage is not reset; only the pointers and count are.
module instr_fifo
  import issue_ctrl_pkg::*;
#(
  parameter int Depth      = QueueDepthDefault,
  parameter int AddrLength = QueueAddrLengthDefault
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear_i,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  logic [PcLength:0]    push_pc_i,
  input  logic [InstrLength:0] push_instr_i,
  output logic                 full_o,
  output logic                 empty_o,
  output logic                 next_empty_o,
  output logic [PcLength:0]    head_pc_o,
  output logic [InstrLength:0] head_instr_o
);

  localparam logic [AddrLength+1:0] DepthCnt = (AddrLength+2)'(Depth);

  logic [PcLength:0]    pc_mem    [Depth];
  logic [InstrLength:0] instr_mem [Depth];

  logic [AddrLength:0]   head_q, head_d;
  logic [AddrLength:0]   tail_q, tail_d;
  logic [AddrLength+1:0] count_q, count_d;
  logic                  push_ok;
  logic                  pop_ok;

  assign full_o       = (count_q == DepthCnt);
  assign empty_o      = (count_q == '0);
  assign next_empty_o = (count_d == '0);

  // Self-protecting: overflow/underflow requests are ignored.
  assign push_ok = push_i & ~full_o & ~clear_i;
  assign pop_ok  = pop_i & ~empty_o & ~clear_i;

  // Pointers are exactly log2(Depth) bits wide, so they wrap naturally.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) tail_d = tail_q + 1'b1;
      if (pop_ok)  head_d = head_q + 1'b1;
      if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
      else if (!push_ok && pop_ok) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      pc_mem[tail_q]    <= push_pc_i;
      instr_mem[tail_q] <= push_instr_i;
    end
  end

  assign head_pc_o    = empty_o ? '0 : pc_mem[head_q];
  assign head_instr_o = empty_o ? '0 : instr_mem[head_q];

endmodule

// File: rtl/issue_ctrl.sv
// Issue controller: buffers fetched instructions and issues the head to
// the decoder when the relevant downstream structures have room; handles
// rob redirects by flushing the queue and pulsing a jump to fetch.
// Ports:
//   clk, rst                          : clock, asynchronous active-low reset
//   valid_from_fetch, pc/instr_from_fetch : fetch offer
//   is_full_to_fetch                  : queue full, fetch holds its offer
//   is_sl_from_dc                     : head is load/store (selects slb vs rs)
//   is_full_from_rob/rs/slb           : downstream full flags
//   is_jump_from_rob, pc_from_rob     : redirect request and target
//   is_empty_to_dc                    : low only in a cycle where head issues
//   pc_to_dc, instr_to_dc             : head entry (zero when empty)
//   is_jump_to_fetch, pc_to_fetch     : registered one-cycle redirect
//   state_dbg_o                       : current FSM state
//   stall_cnt_to_perf                 : saturating STALL-cycle count,
//                                       present only with ISSUE_PERF_EN
// Handshakes: fetch offer transfers at a rising edge when valid_from_fetch=1
// and is_full_to_fetch=0 (and no flush is active or requested); the decoder
// takes the head at a rising edge when is_empty_to_dc=0. Neither side may
// assume a transfer in any other cycle.
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int QueueDepth      = QueueDepthDefault,
  parameter int QueueAddrLength = QueueAddrLengthDefault
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_from_fetch,
  input  logic [PcLength:0]    pc_from_fetch,
  input  logic [InstrLength:0] instr_from_fetch,
  output logic                 is_full_to_fetch,
  input  logic                 is_sl_from_dc,
  input  logic                 is_full_from_rob,
  input  logic                 is_full_from_rs,
  input  logic                 is_full_from_slb,
  input  logic                 is_jump_from_rob,
  input  logic [PcLength:0]    pc_from_rob,
  output logic                 is_empty_to_dc,
  output logic [PcLength:0]    pc_to_dc,
  output logic [InstrLength:0] instr_to_dc,
  output logic                 is_jump_to_fetch,
  output logic [PcLength:0]    pc_to_fetch,
  output state_e               state_dbg_o
`ifdef ISSUE_PERF_EN
  ,
  output logic [31:0]          stall_cnt_to_perf
`endif
);

  state_e            state_q, state_d;
  logic              jump_q, jump_d;
  logic [PcLength:0] pc_fetch_q, pc_fetch_d;

  logic fifo_full;
  logic fifo_empty;
  logic fifo_next_empty;
  logic downstream_full;
  logic issue;
  logic push;

  // The head's class decides which reservation structure must have room.
  assign downstream_full = is_full_from_rob |
                           (is_sl_from_dc ? is_full_from_slb : is_full_from_rs);

  assign issue = ~fifo_empty & (state_q != FLUSH) & ~is_jump_from_rob &
                 ~downstream_full;

  assign push = valid_from_fetch & ~fifo_full & (state_q != FLUSH) &
                ~is_jump_from_rob;

  instr_fifo #(
    .Depth      (QueueDepth),
    .AddrLength (QueueAddrLength)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (is_jump_from_rob),
    .push_i       (push),
    .pop_i        (issue),
    .push_pc_i    (pc_from_fetch),
    .push_instr_i (instr_from_fetch),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .next_empty_o (fifo_next_empty),
    .head_pc_o    (pc_to_dc),
    .head_instr_o (instr_to_dc)
  );

  // A redirect always wins; a flush with no new request drains to IDLE
  // because pushes are blocked during FLUSH.
  always_comb begin
    state_d    = state_q;
    jump_d     = is_jump_from_rob;
    pc_fetch_d = pc_fetch_q;
    if (is_jump_from_rob) begin
      state_d    = FLUSH;
      pc_fetch_d = pc_from_rob;
    end else if (fifo_next_empty) begin
      state_d = IDLE;
    end else if (!fifo_empty && !issue) begin
      state_d = STALL;
    end else begin
      state_d = ISSUE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      jump_q     <= 1'b0;
      pc_fetch_q <= '0;
    end else begin
      state_q    <= state_d;
      jump_q     <= jump_d;
      pc_fetch_q <= pc_fetch_d;
    end
  end

  assign is_full_to_fetch = fifo_full;
  assign is_empty_to_dc   = ~issue;
  assign is_jump_to_fetch = jump_q;
  assign pc_to_fetch      = pc_fetch_q;
  assign state_dbg_o      = state_q;

`ifdef ISSUE_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q == STALL && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_cnt_q <= '0;
    else      stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_to_perf = stall_cnt_q;
`endif

endmodule

// File: tb/tb_issue_ctrl.sv
module tb_issue_ctrl;
  import issue_ctrl_pkg::*;

  localparam int DEPTH = 16;
`ifdef ISSUE_PERF_EN
  localparam int OW = 2 + 3 + 32 * 4;
`else
  localparam int OW = 2 + 3 + 32 * 3;
`endif

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic        valid_from_fetch;
  logic [31:0] pc_from_fetch;
  logic [31:0] instr_from_fetch;
  logic        is_full_to_fetch;
  logic        is_sl_from_dc;
  logic        is_full_from_rob;
  logic        is_full_from_rs;
  logic        is_full_from_slb;
  logic        is_jump_from_rob;
  logic [31:0] pc_from_rob;
  logic        is_empty_to_dc;
  logic [31:0] pc_to_dc;
  logic [31:0] instr_to_dc;
  logic        is_jump_to_fetch;
  logic [31:0] pc_to_fetch;
  state_e      state_dbg;
`ifdef ISSUE_PERF_EN
  logic [31:0] stall_cnt_to_perf;
`endif

  issue_ctrl #(.QueueDepth(DEPTH), .QueueAddrLength(3)) dut (
    .clk              (clk),
    .rst              (rst),
    .valid_from_fetch (valid_from_fetch),
    .pc_from_fetch    (pc_from_fetch),
    .instr_from_fetch (instr_from_fetch),
    .is_full_to_fetch (is_full_to_fetch),
    .is_sl_from_dc    (is_sl_from_dc),
    .is_full_from_rob (is_full_from_rob),
    .is_full_from_rs  (is_full_from_rs),
    .is_full_from_slb (is_full_from_slb),
    .is_jump_from_rob (is_jump_from_rob),
    .pc_from_rob      (pc_from_rob),
    .is_empty_to_dc   (is_empty_to_dc),
    .pc_to_dc         (pc_to_dc),
    .instr_to_dc      (instr_to_dc),
    .is_jump_to_fetch (is_jump_to_fetch),
    .pc_to_fetch      (pc_to_fetch),
    .state_dbg_o      (state_dbg)
`ifdef ISSUE_PERF_EN
    ,
    .stall_cnt_to_perf(stall_cnt_to_perf)
`endif
  );

  // Everything observable packed into one vector for compact comparison.
  wire [OW-1:0] obs = {state_dbg, is_full_to_fetch, is_empty_to_dc,
                       is_jump_to_fetch, pc_to_fetch, pc_to_dc, instr_to_dc
`ifdef ISSUE_PERF_EN
                       , stall_cnt_to_perf
`endif
                      };

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- reference model ----------------
  logic [63:0] exp_q[$];   // {pc, instr}, head at index 0
  state_e      m_state;
  logic        m_jump;
  logic [31:0] m_pcf;
  logic [31:0] m_stall;
  logic        m_issue;
  logic [63:0] m_head;
  logic [OW-1:0] exp_vec;
  logic [OW-1:0] rst_vec;

  task automatic model_reset();
    exp_q.delete();
    m_state = IDLE;
    m_jump  = 1'b0;
    m_pcf   = '0;
    m_stall = '0;
  endtask

  task automatic model_eval();
    int n;
    n = exp_q.size();
    m_issue = (n != 0) && (m_state != FLUSH) && !is_jump_from_rob &&
              !is_full_from_rob &&
              !(is_sl_from_dc ? is_full_from_slb : is_full_from_rs);
    m_head = (n != 0) ? exp_q[0] : 64'd0;
    exp_vec = {m_state, (n == DEPTH), !m_issue, m_jump, m_pcf,
               m_head[63:32], m_head[31:0]
`ifdef ISSUE_PERF_EN
               , m_stall
`endif
              };
  endtask

  task automatic model_commit();
    logic had;
    logic acc;
    model_eval();
    if (m_state == STALL && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
    if (is_jump_from_rob) begin
      exp_q.delete();
      m_state = FLUSH;
      m_pcf   = pc_from_rob;
      m_jump  = 1'b1;
    end else begin
      had = (exp_q.size() != 0);
      acc = valid_from_fetch && (exp_q.size() != DEPTH) && (m_state != FLUSH);
      m_jump = 1'b0;
      if (m_issue) void'(exp_q.pop_front());
      if (acc) exp_q.push_back({pc_from_fetch, instr_from_fetch});
      if (exp_q.size() == 0)   m_state = IDLE;
      else if (had && !m_issue) m_state = STALL;
      else                      m_state = ISSUE;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    valid_from_fetch = 1'b0;
    pc_from_fetch    = '0;
    instr_from_fetch = '0;
    is_sl_from_dc    = 1'b0;
    is_full_from_rob = 1'b0;
    is_full_from_rs  = 1'b0;
    is_full_from_slb = 1'b0;
    is_jump_from_rob = 1'b0;
    pc_from_rob      = '0;
  endtask

  task automatic offer(input logic [31:0] pc, input logic [31:0] ins);
    valid_from_fetch = 1'b1;
    pc_from_fetch    = pc;
    instr_from_fetch = ins;
  endtask

  task automatic settle();
    @(negedge clk);
    model_eval();
  endtask

  task automatic advance();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive_idle();
    rst = 1'b0;
    #3;
    n_checks++;
    if (obs !== rst_vec) $display("FAIL reset_values got=%h want=%h", obs, rst_vec);
    else n_pass++;
    model_reset();
    @(posedge clk); #2;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      settle();
      n_checks++;
      if (obs !== exp_vec) $display("FAIL reset_idle cyc=%0d got=%h want=%h", i, obs, exp_vec);
      else n_pass++;
      advance();
    end
  endtask

  task automatic test_in_order();
    drive_idle();
    for (int i = 0; i < 7; i++) begin
      if (i < 3) offer($urandom, $urandom);
      else valid_from_fetch = 1'b0;
      settle();
      n_checks++;
      if (obs !== exp_vec) $display("FAIL in_order cyc=%0d got=%h want=%h", i, obs, exp_vec);
      else n_pass++;
      // Pushes at edges 0..2 must issue in the cycles right after each.
      if (i >= 1 && i <= 3) begin
        n_checks++;
        if (is_empty_to_dc !== 1'b0) $display("FAIL in_order_issue cyc=%0d got=%b want=0", i, is_empty_to_dc);
        else n_pass++;
      end
      advance();
    end
    n_checks++;
    if (is_empty_to_dc !== 1'b1) $display("FAIL in_order_drained got=%b want=1", is_empty_to_dc);
    else n_pass++;
  endtask

  task automatic test_full_stall();
    int issued;
    drive_idle();
    is_full_from_rob = 1'b1;
    for (int i = 0; i < 20; i++) begin
      offer(32'h1000 + 32'(exp_q.size()) * 4, 32'hA000_0000 + 32'(exp_q.size()));
      settle();
      n_checks++;
      if (obs !== exp_vec) $display("FAIL fill cyc=%0d got=%h want=%h", i, obs, exp_vec);
      else n_pass++;
      advance();
    end
    settle();
    n_checks++;
    if (is_full_to_fetch !== 1'b1 || state_dbg !== STALL)
      $display("FAIL full_stall got full=%b state=%0d want full=1 state=%0d",
               is_full_to_fetch, state_dbg, STALL);
    else n_pass++;
    @(posedge clk); #1;
    is_full_from_rob = 1'b0;
    valid_from_fetch = 1'b0;
    issued = 0;
    for (int i = 0; i < 17; i++) begin
      settle();
      if (i < 16 && is_empty_to_dc === 1'b0) issued++;
      n_checks++;
      if (obs !== exp_vec) $display("FAIL drain cyc=%0d got=%h want=%h", i, obs, exp_vec);
      else n_pass++;
      advance();
    end
    n_checks++;
    if (issued != 16) $display("FAIL drain_consecutive got=%0d want=16", issued);
    else n_pass++;
  endtask

  task automatic test_sl_routing();
    drive_idle();
    is_sl_from_dc    = 1'b1;
    is_full_from_slb = 1'b1;
    offer(32'h0000_2000, 32'h0000_2003);
    for (int i = 0; i < 6; i++) begin
      if (i == 1) valid_from_fetch = 1'b0;
      if (i == 4) begin
        is_full_from_slb = 1'b0;
        is_full_from_rs  = 1'b1;
      end
      settle();
      n_checks++;
      if (obs !== exp_vec) $display("FAIL sl_route cyc=%0d got=%h want=%h", i, obs, exp_vec);
      else n_pass++;
      n_checks++;
      if (is_empty_to_dc !== ((i == 4) ? 1'b0 : 1'b1))
        $display("FAIL sl_route_issue cyc=%0d got=%b want=%b", i, is_empty_to_dc, (i != 4));
      else n_pass++;
      advance();
    end
  endtask

  task automatic test_flush();
    drive_idle();
    is_full_from_rob = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i < 5) offer($urandom, $urandom);
      else if (i == 5) begin
        offer(32'hDEAD_0000, 32'hBEEF_0000);
        is_jump_from_rob = 1'b1;
        pc_from_rob      = 32'h0000_0100;
      end else begin
        drive_idle();
      end
      settle();
      n_checks++;
      if (obs !== exp_vec) $display("FAIL flush cyc=%0d got=%h want=%h", i, obs, exp_vec);
      else n_pass++;
      if (i == 6) begin
        n_checks++;
        if (is_jump_to_fetch !== 1'b1 || pc_to_fetch !== 32'h100 || pc_to_dc !== 32'h0 ||
            is_empty_to_dc !== 1'b1)
          $display("FAIL flush_pulse got jump=%b pc=%h head=%h want jump=1 pc=100 head=0",
                   is_jump_to_fetch, pc_to_fetch, pc_to_dc);
        else n_pass++;
      end
      if (i == 7) begin
        n_checks++;
        if (is_jump_to_fetch !== 1'b0) $display("FAIL flush_one_cycle got=%b want=0", is_jump_to_fetch);
        else n_pass++;
      end
      advance();
    end
  endtask

  task automatic test_full_push_pop();
    drive_idle();
    is_full_from_rob = 1'b1;
    for (int i = 0; i < 18; i++) begin
      offer($urandom, $urandom);
      if (i == 16) is_full_from_rob = 1'b0;  // full queue: pop plus offered push
      if (i == 17) drive_idle();
      settle();
      n_checks++;
      if (obs !== exp_vec) $display("FAIL full_pp cyc=%0d got=%h want=%h", i, obs, exp_vec);
      else n_pass++;
      if (i == 17) begin
        n_checks++;
        if (is_full_to_fetch !== 1'b0) $display("FAIL full_pp_rejected got=%b want=0", is_full_to_fetch);
        else n_pass++;
      end
      advance();
    end
    // Wrap: well over 40 entries through the ring with random back-pressure.
    for (int i = 0; i < 160; i++) begin
      if ($urandom_range(3, 0) != 0) offer($urandom, $urandom);
      else valid_from_fetch = 1'b0;
      is_sl_from_dc    = 1'($urandom_range(1, 0));
      is_full_from_rob = ($urandom_range(4, 0) == 0);
      is_full_from_rs  = ($urandom_range(3, 0) == 0);
      is_full_from_slb = ($urandom_range(3, 0) == 0);
      settle();
      n_checks++;
      if (obs !== exp_vec) $display("FAIL wrap cyc=%0d got=%h want=%h", i, obs, exp_vec);
      else n_pass++;
      advance();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      valid_from_fetch = 1'($urandom_range(1, 0));
      pc_from_fetch    = $urandom;
      instr_from_fetch = $urandom;
      is_sl_from_dc    = 1'($urandom_range(1, 0));
      is_full_from_rob = ($urandom_range(2, 0) == 0);
      is_full_from_rs  = ($urandom_range(3, 0) == 0);
      is_full_from_slb = ($urandom_range(3, 0) == 0);
      is_jump_from_rob = ($urandom_range(15, 0) == 0);
      pc_from_rob      = $urandom;
      settle();
      n_checks++;
      if (obs !== exp_vec) $display("FAIL random cyc=%0d got=%h want=%h", i, obs, exp_vec);
      else n_pass++;
      advance();
    end
  endtask

  task automatic test_reset_mid_stall();
    drive_idle();
    is_full_from_rob = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i < 7) offer($urandom, $urandom);
      else valid_from_fetch = 1'b0;
      settle();
      n_checks++;
      if (obs !== exp_vec) $display("FAIL pre_rst cyc=%0d got=%h want=%h", i, obs, exp_vec);
      else n_pass++;
      advance();
    end
    settle();
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (obs !== rst_vec) $display("FAIL rst_mid_stall got=%h want=%h", obs, rst_vec);
    else n_pass++;
    model_reset();
    @(posedge clk); #2;
    drive_idle();
    rst = 1'b1;
    offer(32'h0000_3000, 32'h0000_3333);
    for (int i = 0; i < 4; i++) begin
      if (i == 1) valid_from_fetch = 1'b0;
      settle();
      n_checks++;
      if (obs !== exp_vec) $display("FAIL post_rst cyc=%0d got=%h want=%h", i, obs, exp_vec);
      else n_pass++;
      if (i == 1) begin
        n_checks++;
        if (pc_to_dc !== 32'h3000 || is_empty_to_dc !== 1'b0)
          $display("FAIL post_rst_first_push got pc=%h empty=%b want pc=3000 empty=0",
                   pc_to_dc, is_empty_to_dc);
        else n_pass++;
      end
      advance();
    end
  endtask

  initial begin
    rst_vec = {IDLE, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0
`ifdef ISSUE_PERF_EN
               , 32'd0
`endif
              };
    test_reset();
    test_in_order();
    test_full_stall();
    test_sl_routing();
    test_flush();
    test_full_push_pop();
    test_random();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
